// File: rtl/fadd_sub_4bit_d_pkg.sv
// Shared constants and types for the 4-bit add/subtract block.
//   DATA_W   : datapath width (4)
//   mode_e   : s-input encoding (MODE_ADD=0, MODE_SUB=1)
//   result_t : {carry, sum} payload held by the register stage
package fadd_sub_4bit_d_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] sum;
  } result_t;

endpackage

// File: rtl/fadd_sub_4bit_d_full_adder.sv
// One-bit full adder, the ripple-chain cell.
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fadd_sub_4bit_s.sv
// Combinational 4-bit ripple adder/subtractor: a + (b ^ {4{s}}) + s.
//   a, b  : unsigned operands
//   s     : 0 = add, 1 = subtract
//   sum   : low 4 bits of the result
//   carry : carry (add) or borrow (subtract)
//   ovf   : signed overflow, only with FADD_SUB_OVF_EN defined
module fadd_sub_4bit_s
  import fadd_sub_4bit_d_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              s,
`ifdef FADD_SUB_OVF_EN
  output logic              ovf,
`endif
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic              sub;
  logic [DATA_W-1:0] bx;
  logic [DATA_W:0]   c;

  assign sub  = (mode_e'(s) == MODE_SUB);
  assign bx   = b ^ {DATA_W{sub}};
  assign c[0] = sub;

  // Ripple chain of full adders
  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (bx[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  // Inverting carry-out in subtract mode turns "no borrow" into borrow=0
  assign carry = c[DATA_W] ^ sub;

`ifdef FADD_SUB_OVF_EN
  assign ovf = c[DATA_W-1] ^ c[DATA_W];
`endif

endmodule

// File: rtl/fadd_sub_4bit_d.sv
// 4-bit ripple adder/subtractor with a one-cycle output register stage.
// Optional signed-overflow outputs are enabled by defining FADD_SUB_OVF_EN.
//   clk, reset_n      : clock, async active-low reset
//   a, b, s, in_valid : operands, mode (0 add / 1 sub), capture qualifier
//   sum, carry        : combinational result
//   sum_q, carry_q    : registered result
//   ovf, ovf_q        : signed overflow, comb and registered (optional)
//   out_valid         : one-cycle pulse on a freshly captured result
module fadd_sub_4bit_d
  import fadd_sub_4bit_d_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              s,
  input  logic              in_valid,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic [DATA_W-1:0] sum_q,
  output logic              carry_q,
`ifdef FADD_SUB_OVF_EN
  output logic              ovf,
  output logic              ovf_q,
`endif
  output logic              out_valid
);

  result_t res_q;

  fadd_sub_4bit_s u_core (
    .a     (a),
    .b     (b),
    .s     (s),
`ifdef FADD_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .sum   (sum),
    .carry (carry)
  );

  // Capture register: loads on in_valid, otherwise holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res_q.sum   <= sum;
        res_q.carry <= carry;
      end
    end
  end

`ifdef FADD_SUB_OVF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf;
    end
  end
`endif

  assign sum_q   = res_q.sum;
  assign carry_q = res_q.carry;

endmodule

// File: tb/tb_fadd_sub_4bit_d.sv
// Self-checking bench for fadd_sub_4bit_d (FADD_SUB_OVF_EN optional).
module tb_fadd_sub_4bit_d;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] a, b;
  logic       s, in_valid;
  logic [3:0] sum, sum_q;
  logic       carry, carry_q, out_valid;
`ifdef FADD_SUB_OVF_EN
  logic       ovf, ovf_q;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[8];

  fadd_sub_4bit_d dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .s         (s),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .sum_q     (sum_q),
    .carry_q   (carry_q),
`ifdef FADD_SUB_OVF_EN
    .ovf       (ovf),
    .ovf_q     (ovf_q),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input int e_sum, input int e_carry, input int e_vld);
    chk({name, ".sum_q"},     int'(sum_q),     e_sum);
    chk({name, ".carry_q"},   int'(carry_q),   e_carry);
    chk({name, ".out_valid"}, int'(out_valid), e_vld);
  endtask

  initial begin
    int e;
    vecs[0] = '{1'b0, 4'd15, 4'd1,  4'd0,  1'b1};
    vecs[1] = '{1'b0, 4'd15, 4'd15, 4'd14, 1'b1};
    vecs[2] = '{1'b1, 4'd3,  4'd5,  4'd14, 1'b1};
    vecs[3] = '{1'b1, 4'd9,  4'd4,  4'd5,  1'b0};
    vecs[4] = '{1'b1, 4'd15, 4'd15, 4'd0,  1'b0};
    vecs[5] = '{1'b0, 4'd0,  4'd0,  4'd0,  1'b0};
    vecs[6] = '{1'b1, 4'd0,  4'd1,  4'd15, 1'b1};
    vecs[7] = '{1'b0, 4'd6,  4'd7,  4'd13, 1'b0};

    // Reset state, with combinational path live during reset
    reset_n = 1'b0; in_valid = 1'b0; a = 4'd15; b = 4'd1; s = 1'b0;
    #2;
    chk_q("reset", 0, 0, 0);
    chk("reset.comb_sum", int'(sum), 0);
    chk("reset.comb_carry", int'(carry), 1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; s = vecs[i].s;
      #1;
      chk($sformatf("vec%0d.sum", i), int'(sum), int'(vecs[i].exp_sum));
      chk($sformatf("vec%0d.carry", i), int'(carry), int'(vecs[i].exp_carry));
    end

    // Exhaustive sweep against arithmetic model
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          s = 1'(m); a = 4'(x); b = 4'(y);
          #1;
          if (m == 0) e = x + y;
          else        e = ((x < y) ? 16 : 0) + ((x - y + 16) % 16);
          chk($sformatf("sweep s=%0d a=%0d b=%0d", m, x, y), int'({carry, sum}), e);
        end

`ifdef FADD_SUB_OVF_EN
    a = 4'd7; b = 4'd1; s = 1'b0; #1; chk("ovf 7+1", int'(ovf), 1);
    a = 4'd8; b = 4'd1; s = 1'b1; #1; chk("ovf 8-1", int'(ovf), 1);
    a = 4'd2; b = 4'd1; s = 1'b1; #1; chk("ovf 2-1", int'(ovf), 0);
`endif

    // Release reset, single capture
    @(negedge clk);
    reset_n = 1'b1;
    a = 4'd6; b = 4'd7; s = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_q("cap", 13, 0, 1);

    // Hold with in_valid low
    @(negedge clk);
    in_valid = 1'b0; a = 4'd3; b = 4'd5; s = 1'b1;
    @(posedge clk); #1;
    chk_q("hold", 13, 0, 0);

    // Back-to-back captures
    @(negedge clk);
    in_valid = 1'b1; a = 4'd3; b = 4'd5; s = 1'b1;
    @(posedge clk); #1;
    chk_q("b2b0", 14, 1, 1);
    @(negedge clk);
    a = 4'd15; b = 4'd15; s = 1'b0;
    @(posedge clk); #1;
    chk_q("b2b1", 14, 1, 1);
`ifdef FADD_SUB_OVF_EN
    @(negedge clk);
    a = 4'd7; b = 4'd1; s = 1'b0;
    @(posedge clk); #1;
    chk("ovf_q", int'(ovf_q), 1);
`endif

    // Reset between edges clears immediately
    reset_n = 1'b0;
    #1;
    chk_q("midrst", 0, 0, 0);
`ifdef FADD_SUB_OVF_EN
    chk("midrst.ovf_q", int'(ovf_q), 0);
`endif

    // Edge during reset with in_valid high is discarded
    @(posedge clk); #1;
    chk_q("rst_edge", 0, 0, 0);

    // First capture after release
    @(negedge clk);
    reset_n = 1'b1; a = 4'd9; b = 4'd4; s = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_q("first", 5, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_q("first_hold", 5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
